update_knn4_mul_arb: RTL and testbench
======================================

Name: update_knn4_mul_arb

Overview:
- Shares one pipelined unsigned 17x15 -> 32 multiplier among NUM_REQ requesters inside the update_knn4 datapath.
- Requesters see a valid/ready request port each. One shared response port returns every product tagged with its requester ID.
- The block performs round-robin arbitration and drives the multiplier's ce. It tracks in-flight operations with a shadow valid/tag pipeline and stalls the whole pipe on response backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_WIDTH, 2, width of requester ID; equals clog2(NUM_REQ)
- A_WIDTH, 17, operand A width (multiplier din0)
- B_WIDTH, 15, operand B width (multiplier din1)
- P_WIDTH, 32, product width (multiplier dout)
- MUL_LATENCY, 2, ce-qualified cycles from operand capture to product valid

Ports:
- clk, input, 1, single clock; rising edge
- reset, input, 1, asynchronous, active-high reset
- req_valid, input, NUM_REQ, per-requester request valid
- req_ready, output, NUM_REQ, per-requester accept
- req_a, input, NUM_REQ*A_WIDTH, operand A; requester i occupies slice [i*A_WIDTH +: A_WIDTH]
- req_b, input, NUM_REQ*B_WIDTH, operand B; same slicing as req_a
- mul_ce, output, 1, clock enable to the shared multiplier
- mul_din0, output, A_WIDTH, operand A to the multiplier
- mul_din1, output, B_WIDTH, operand B to the multiplier
- mul_dout, input, P_WIDTH, product from the multiplier
- rsp_valid, output, 1, response valid
- rsp_ready, input, 1, response accept from the consumer
- rsp_id, output, ID_WIDTH, requester ID of the current response
- rsp_data, output, P_WIDTH, product; equals mul_dout
- busy, output, 1, any operation in flight
- issue_cnt, output, 16, count of accepted requests; wraps

Behaviour:
- Reset (async assert, sync deassert by user):
  - vld[0..MUL_LATENCY-1]=0, tags=0, rr_ptr=0, issue_cnt=0.
  - Hence rsp_valid=0 and busy=0.
  - mul_ce=1 while reset is asserted.
- Stall:
  - stall = rsp_valid & ~rsp_ready.
  - mul_ce = ~stall (combinational).
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr, ascending with wrap.
  - The first asserted index wins: gnt one-hot, gnt_id.
  - No request -> gnt=0.
- Request handshake:
  - req_ready[i] = gnt[i] & mul_ce. At most one bit is set.
  - Accept = any req_ready bit set together with its req_valid.
  - rsp_ready -> req_ready is a combinational path; this is permitted.
- Operand mux:
  - mul_din0 = req_a slice of gnt_id; mul_din1 = req_b slice of gnt_id.
  - No grant -> both driven to 0.
- On an accept edge:
  - rr_ptr <= (gnt_id+1) mod NUM_REQ.
  - issue_cnt++.
- Without an accept, rr_ptr holds.
- Shadow pipeline, advances only when mul_ce=1:
  - vld[0] <= accept; tag[0] <= gnt_id.
  - vld[k] <= vld[k-1]; tag[k] <= tag[k-1], for k = 1..MUL_LATENCY-1.
  - When mul_ce=0, all stages hold.
- Response:
  - rsp_valid = vld[MUL_LATENCY-1]; rsp_id = tag[MUL_LATENCY-1]; rsp_data = mul_dout.
  - Product is valid exactly MUL_LATENCY mul_ce=1 edges after the accept edge.
- Outputs under stall:
  - rsp_valid, rsp_id and rsp_data stay stable.
  - mul_dout is stable because the multiplier's ce is low.
- busy = OR of all vld stages.
- Throughput and ordering:
  - One accept per cycle when there is no stall.
  - Responses come out in issue order.
- Simultaneous events:
  - Response accept and new request accept occur in the same cycle; the pipe shifts normally.
  - All requesters valid: strict rotation 0,1,2,3,0...
  - A single persistent requester is granted every cycle.
- Reset mid-operation: all vld clear immediately. The multiplier's internal registers are not reset; their stale products are discarded because no vld is set.
- Arithmetic: unsigned. Full product fits P_WIDTH; no truncation.
- issue_cnt wraps 0xFFFF -> 0x0000.

Test Plan:
- Single request: req 2 valid, a=3, b=5, rsp_ready=1 -> req_ready[2]=1 in cycle 0; rsp_valid=1, rsp_id=2, rsp_data=15 at cycle 2 (two edges later); busy high for cycles 1-2.
- Max operands: a=0x1FFFF, b=0x7FFF -> rsp_data=0xFFFD8001.
- All 4 requesters hold valid for 8 cycles, distinct operands -> accept order 0,1,2,3,0,1,2,3, one per cycle; responses in the same order with correct products; issue_cnt=8.
- Backpressure: rsp_ready low 3 cycles while rsp_valid=1 ->
  - mul_ce=0 and req_ready=0 for those cycles.
  - rsp_id and rsp_data held stable.
  - After release, the remaining in-flight results emerge with no loss or duplication.
- Reset mid-flight: assert reset with 2 operations in flight -> rsp_valid=0 and busy=0 immediately; after release the first new request is served from rr_ptr=0 with a correct product, and no stale response appears.
- Counter wrap: issue 65537 requests -> issue_cnt=1.

Source files
------------

// File: rtl/update_knn4_mul_arb.sv
// update_knn4_mul_arb
// Round-robin arbiter sharing one pipelined unsigned multiplier among several
// requesters. A shadow valid/tag pipeline follows each operation through the
// multiplier so the product can be returned tagged with its requester ID.
// The whole pipe, multiplier included, freezes while the response is held off.
module update_knn4_mul_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int A_WIDTH     = 17,
  parameter int B_WIDTH     = 15,
  parameter int P_WIDTH     = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic                        mul_ce,
  output logic [A_WIDTH-1:0]          mul_din0,
  output logic [B_WIDTH-1:0]          mul_din1,
  input  logic [P_WIDTH-1:0]          mul_dout,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic [P_WIDTH-1:0]          rsp_data,
  output logic                        busy,
  output logic [15:0]                 issue_cnt
);

  // Requester index following 'idx', wrapping at NUM_REQ (which need not be
  // a power of two, so a plain ID_WIDTH-bit increment is not enough).
  function automatic logic [ID_WIDTH-1:0] nextId(input logic [ID_WIDTH-1:0] idx);
    logic [ID_WIDTH:0] sum;
    sum = {1'b0, idx} + {{ID_WIDTH{1'b0}}, 1'b1};
    if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
      sum = '0;
    end
    return sum[ID_WIDTH-1:0];
  endfunction

  logic [ID_WIDTH-1:0] rrPtr_q;
  logic [ID_WIDTH-1:0] rrPtr_d;
  logic [15:0]         issueCnt_q;
  logic [15:0]         issueCnt_d;
  logic [MUL_LATENCY-1:0] vld_q;
  logic [ID_WIDTH-1:0]    tag_q [MUL_LATENCY];

  logic                stall;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_WIDTH-1:0] gntId;
  logic                gntAny;
  logic                accept;

  // Backpressure: a response that cannot leave freezes the multiplier and
  // every shadow stage, so nothing in flight is overwritten.
  always_comb begin
    stall  = vld_q[MUL_LATENCY-1] & ~rsp_ready;
    mul_ce = ~stall;
  end

  // Round-robin search starting at rrPtr_q; the first valid requester wins.
  always_comb begin
    logic [ID_WIDTH-1:0] idx;
    gnt    = '0;
    gntId  = '0;
    gntAny = 1'b0;
    idx    = rrPtr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gntAny && req_valid[idx]) begin
        gntAny     = 1'b1;
        gntId      = idx;
        gnt[idx]   = 1'b1;
      end
      idx = nextId(idx);
    end
  end

  // Grant is only honoured when the pipe is moving; a request can only be
  // accepted on a cycle where its operands are actually captured.
  always_comb begin
    req_ready = mul_ce ? gnt : '0;
    accept    = |(req_ready & req_valid);
  end

  // Steer the granted requester's operands to the multiplier; idle inputs
  // are forced to zero so the multiplier sees a quiet bus.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (gntAny) begin
      mul_din0 = req_a[gntId*A_WIDTH +: A_WIDTH];
      mul_din1 = req_b[gntId*B_WIDTH +: B_WIDTH];
    end
  end

  // Next pointer and counter: the pointer moves just past the winner so the
  // winner becomes lowest priority next time; the counter simply wraps.
  always_comb begin
    rrPtr_d    = rrPtr_q;
    issueCnt_d = issueCnt_q;
    if (accept) begin
      rrPtr_d    = nextId(gntId);
      issueCnt_d = issueCnt_q + 16'd1;
    end
  end

  // Arbitration pointer and accepted-request counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr_q    <= '0;
      issueCnt_q <= '0;
    end else begin
      rrPtr_q    <= rrPtr_d;
      issueCnt_q <= issueCnt_d;
    end
  end

  // Shadow pipeline mirroring the multiplier's stages; it advances on the
  // same enable so each tag lines up with its product at the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else if (mul_ce) begin
      vld_q[0] <= accept;
      tag_q[0] <= gntId;
      for (int k = 1; k < MUL_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Response side is the last shadow stage plus the raw multiplier output.
  always_comb begin
    rsp_valid = vld_q[MUL_LATENCY-1];
    rsp_id    = tag_q[MUL_LATENCY-1];
    rsp_data  = mul_dout;
    busy      = |vld_q;
    issue_cnt = issueCnt_q;
  end

endmodule

// File: tb/tb_update_knn4_mul_arb.sv
// Testbench for update_knn4_mul_arb: models the shared multiplier, predicts
// arbitration, and scoreboards every response against the operands driven.
module tb_update_knn4_mul_arb;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;
  localparam int AW      = 17;
  localparam int BW      = 15;
  localparam int PW      = 32;
  localparam int LAT     = 2;

  logic                   clk;
  logic                   reset;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*AW-1:0]  req_a;
  logic [NUM_REQ*BW-1:0]  req_b;
  logic                   mul_ce;
  logic [AW-1:0]          mul_din0;
  logic [BW-1:0]          mul_din1;
  logic [PW-1:0]          mul_dout;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [PW-1:0]          rsp_data;
  logic                   busy;
  logic [15:0]            issue_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [PW-1:0]  p;
  } exp_t;
  exp_t expQ[$];

  logic [IDW-1:0] rrM;
  logic [15:0]    cntM;

  update_knn4_mul_arb #(
    .NUM_REQ(NUM_REQ), .ID_WIDTH(IDW), .A_WIDTH(AW), .B_WIDTH(BW),
    .P_WIDTH(PW), .MUL_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
    .mul_dout(mul_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared multiplier: LAT enabled stages, never reset.
  logic [PW-1:0] mulPipe [LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      mulPipe[0] <= PW'(mul_din0) * PW'(mul_din1);
      for (int k = 1; k < LAT; k++) mulPipe[k] <= mulPipe[k-1];
    end
  end
  assign mul_dout = mulPipe[LAT-1];

  // Arbitration prediction and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    logic               expCe;
    logic [NUM_REQ-1:0] expGnt;
    logic [NUM_REQ-1:0] expReady;
    logic [IDW-1:0]     expId;
    logic               found;
    int                 idx;
    exp_t               e;
    if (reset) begin
      expQ.delete();
      rrM  = '0;
      cntM = '0;
    end else begin
      expCe  = !(rsp_valid && !rsp_ready);
      checks++;
      if (mul_ce !== expCe) begin
        errors++;
        $display("[TB] FAIL mul_ce at %0t: got %b want %b", $time, mul_ce, expCe);
      end
      expGnt = '0;
      expId  = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rrM) + k) % NUM_REQ;
        if (!found && req_valid[idx]) begin
          found       = 1'b1;
          expGnt[idx] = 1'b1;
          expId       = IDW'(idx);
        end
      end
      expReady = expCe ? expGnt : '0;
      checks++;
      if (req_ready !== expReady) begin
        errors++;
        $display("[TB] FAIL req_ready at %0t: got %b want %b", $time, req_ready, expReady);
      end
      checks++;
      if (issue_cnt !== cntM) begin
        errors++;
        $display("[TB] FAIL issue_cnt at %0t: got %h want %h", $time, issue_cnt, cntM);
      end
      if (|(expReady & req_valid)) begin
        e.id = expId;
        e.p  = PW'(req_a[expId*AW +: AW]) * PW'(req_b[expId*BW +: BW]);
        expQ.push_back(e);
        rrM  = IDW'((int'(expId) + 1) % NUM_REQ);
        cntM = cntM + 16'd1;
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_rsp at %0t: got id=%0d data=%h want none", $time, rsp_id, rsp_data);
        end else begin
          e = expQ.pop_front();
          if (rsp_id !== e.id || rsp_data !== e.p) begin
            errors++;
            $display("[TB] FAIL rsp at %0t: got id=%0d data=%h want id=%0d data=%h",
                     $time, rsp_id, rsp_data, e.id, e.p);
          end
        end
      end
    end
  end

  task automatic applyIdle();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic randomOps();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*AW +: AW] = AW'($urandom);
      req_b[i*BW +: BW] = BW'($urandom);
    end
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1;
    applyIdle();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((busy !== 1'b0 || expQ.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain: got busy=%b pending=%0d want busy=0 pending=0",
               name, busy, expQ.size());
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    rsp_ready = 1'b1;
    applyIdle();
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || mul_ce !== 1'b1 || issue_cnt !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_state: got rsp_valid=%b busy=%b ce=%b cnt=%h want 0 0 1 0000",
               rsp_valid, busy, mul_ce, issue_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: got req_ready=%b rsp_valid=%b want 0000 0",
               req_ready, rsp_valid);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req_valid = 4'b0100;
    req_a[2*AW +: AW] = AW'(3);
    req_b[2*BW +: BW] = BW'(5);
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_c0: got ready=%b busy=%b want 0100 0", req_ready, busy);
    end
    @(posedge clk); #1;
    applyIdle();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_c1: got busy=%b rsp_valid=%b want 1 0", busy, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'd15) begin
      errors++;
      $display("[TB] FAIL single_c2: got busy=%b v=%b id=%0d data=%0d want 1 1 2 15",
               busy, rsp_valid, rsp_id, rsp_data);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_c3: got busy=%b rsp_valid=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_max_operands();
    int n = 0;
    @(posedge clk); #1;
    req_valid = 4'b0010;
    req_a[1*AW +: AW] = 17'h1FFFF;
    req_b[1*BW +: BW] = 15'h7FFF;
    @(posedge clk); #1;
    applyIdle();
    @(negedge clk);
    while (rsp_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hFFFD8001) begin
      errors++;
      $display("[TB] FAIL max_operands: got v=%b id=%0d data=%h want 1 1 fffd8001",
               rsp_valid, rsp_id, rsp_data);
    end
    drain("max");
  endtask

  task automatic test_rotation();
    logic [NUM_REQ-1:0] want;
    doReset();
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      randomOps();
      @(negedge clk);
      want = 4'b0001 << (c % NUM_REQ);
      checks++;
      if (req_ready !== want) begin
        errors++;
        $display("[TB] FAIL rotation_c%0d: got %b want %b", c, req_ready, want);
      end
      @(posedge clk); #1;
    end
    applyIdle();
    checks++;
    if (issue_cnt !== 16'd8) begin
      errors++;
      $display("[TB] FAIL rotation_cnt: got %0d want 8", issue_cnt);
    end
    drain("rotation");
  endtask

  task automatic test_back_to_back_stall();
    logic [IDW-1:0] holdId;
    logic [PW-1:0]  holdData;
    doReset();
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      randomOps();
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      randomOps();
      @(negedge clk);
      if (c == 0) begin
        holdId   = rsp_id;
        holdData = rsp_data;
      end
      checks++;
      if (mul_ce !== 1'b0 || req_ready !== 4'b0000 || rsp_valid !== 1'b1 ||
          rsp_id !== holdId || rsp_data !== holdData) begin
        errors++;
        $display("[TB] FAIL stall_c%0d: got ce=%b ready=%b v=%b id=%0d data=%h want 0 0000 1 %0d %h",
                 c, mul_ce, req_ready, rsp_valid, rsp_id, rsp_data, holdId, holdData);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    applyIdle();
    drain("stall");
  endtask

  task automatic test_reset_midflight();
    req_valid = 4'b1000;
    req_a[3*AW +: AW] = AW'(1234);
    req_b[3*BW +: BW] = BW'(77);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    applyIdle();
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midflight: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    req_valid = 4'b1111;
    randomOps();
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL reset_rr_ptr: got %b want 0001", req_ready);
    end
    @(posedge clk); #1;
    applyIdle();
    drain("reset_midflight");
  endtask

  task automatic test_counter_wrap();
    doReset();
    req_valid = 4'b0001;
    req_a[AW-1:0] = AW'(9);
    req_b[BW-1:0] = BW'(11);
    repeat (65537) @(posedge clk);
    #1;
    applyIdle();
    checks++;
    if (issue_cnt !== 16'd1) begin
      errors++;
      $display("[TB] FAIL counter_wrap: got %0d want 1", issue_cnt);
    end
    drain("wrap");
  endtask

  initial begin
    test_reset();
    test_single();
    test_max_operands();
    test_rotation();
    test_back_to_back_stall();
    test_reset_midflight();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
